// File: rtl/cmd_frame_pkg.sv
// Shared definitions for the command frame parser.
//   state_e : parser FSM states
//   op_e    : command byte operation field [7:6]
//   err_e   : error codes reported on err_code
package cmd_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_TAIL
  } state_e;

  typedef enum logic [1:0] {
    OP_OFF = 2'b00,
    OP_ON  = 2'b01,
    OP_TOG = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_LEN  = 3'd1,
    ERR_CMD  = 3'd2,
    ERR_CHK  = 3'd3,
    ERR_TAIL = 3'd4,
    ERR_TMO  = 3'd5
  } err_e;

  // LEN never exceeds 15, so the remaining-command count fits in a nibble.
  localparam int REM_W = 4;

endpackage

// File: rtl/cmd_timeout_timer.sv
// Inter-byte timeout timer.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart counting (a byte arrived)
//   en       : count only while a frame is in progress
//   expire   : high while the idle count sits at TIMEOUT_CYC with no byte
// With TIMEOUT_CYC = 0 the counter is not built and expire is tied low.
module cmd_timeout_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clr, en};
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC);

      logic [CW-1:0] cnt;

      // Count idle clocks since the last byte; park at the terminal value
      // so the count can never wrap back into range.
      always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
          cnt <= '0;
        end else if (cnt != TERM) begin
          cnt <= cnt + 1'b1;
        end
      end

      // A byte arriving on the terminal count wins over the timeout.
      assign expire = en && !clr && (cnt == TERM);
    end
  endgenerate

endmodule

// File: rtl/cmd_frame_parser.sv
// Variable-length command frame parser: HEAD, LEN, LEN command bytes, CHK, TAIL.
// Commands build up in a shadow vector that is copied to cmd_out only when a
// complete, valid frame has been received.
//   clk, rst  : clock, synchronous active-high reset
//   din_vld   : one-cycle strobe qualifying din
//   din       : received byte
//   cmd_out   : committed channel states
//   frame_ok  : one-cycle pulse when a frame commits
//   frame_err : one-cycle pulse when a frame aborts
//   err_code  : code of the most recent error (held)
//   busy      : FSM is inside a frame
//   ok_cnt    : saturating good-frame count
//   err_cnt   : saturating aborted-frame count
module cmd_frame_parser
  import cmd_frame_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          MAX_CMDS    = 4,
  parameter logic [7:0]  HEAD        = 8'h55,
  parameter logic [7:0]  TAIL        = 8'hFF,
  parameter int          TIMEOUT_CYC = 50000,
  parameter int          CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_vld,
  input  logic [7:0]        din,
  output logic [NUM_CH-1:0] cmd_out,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [2:0]        err_code,
  output logic              busy,
  output logic [CNT_W-1:0]  ok_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  state_e            state;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] shadow_nxt;
  logic [7:0]        chk;
  logic [REM_W-1:0]  rem;
  op_e               op;
  logic [5:0]        idx;
  logic              expire;
  logic              err_det;
  err_e              err_det_code;

  assign op  = op_e'(din[7:6]);
  assign idx = din[5:0];

  cmd_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (din_vld),
    .en    (state != S_IDLE),
    .expire(expire)
  );

  // Shadow vector with the current command byte applied. Looping over the
  // channels keeps the index width independent of NUM_CH.
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == 6'(i)) begin
        case (op)
          OP_OFF:  shadow_nxt[i] = 1'b0;
          OP_ON:   shadow_nxt[i] = 1'b1;
          OP_TOG:  shadow_nxt[i] = ~shadow[i];
          default: shadow_nxt[i] = shadow[i];
        endcase
      end
    end
  end

  // Error detection for the byte (or idle clock) seen in the current state.
  // A timeout can only fire on a clock with no byte.
  always_comb begin
    err_det      = 1'b0;
    err_det_code = ERR_NONE;
    if (state != S_IDLE) begin
      if (din_vld) begin
        case (state)
          S_LEN: begin
            if (din == 8'h00 || din > 8'(MAX_CMDS)) begin
              err_det      = 1'b1;
              err_det_code = ERR_LEN;
            end
          end
          S_DATA: begin
            if (op == OP_RSV || {1'b0, idx} >= 7'(NUM_CH)) begin
              err_det      = 1'b1;
              err_det_code = ERR_CMD;
            end
          end
          S_CHK: begin
            if (din != chk) begin
              err_det      = 1'b1;
              err_det_code = ERR_CHK;
            end
          end
          S_TAIL: begin
            if (din != TAIL) begin
              err_det      = 1'b1;
              err_det_code = ERR_TAIL;
            end
          end
          default: ;
        endcase
      end else if (expire) begin
        err_det      = 1'b1;
        err_det_code = ERR_TMO;
      end
    end
  end

  // Frame FSM with registered status outputs. An error always takes
  // precedence and consumes the offending byte, so it is never re-read as HEAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shadow    <= '0;
      chk       <= '0;
      rem       <= '0;
      cmd_out   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 3'd0;
      busy      <= 1'b0;
      ok_cnt    <= '0;
      err_cnt   <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (err_det) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        frame_err <= 1'b1;
        err_code  <= err_det_code;
        if (err_cnt != {CNT_W{1'b1}}) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end else if (din_vld) begin
        case (state)
          S_IDLE: begin
            if (din == HEAD) begin
              shadow <= cmd_out;
              chk    <= 8'h00;
              state  <= S_LEN;
              busy   <= 1'b1;
            end
          end
          S_LEN: begin
            rem   <= din[REM_W-1:0];
            chk   <= chk ^ din;
            state <= S_DATA;
          end
          S_DATA: begin
            shadow <= shadow_nxt;
            chk    <= chk ^ din;
            rem    <= rem - 1'b1;
            if (rem == REM_W'(1)) begin
              state <= S_CHK;
            end
          end
          S_CHK: begin
            state <= S_TAIL;
          end
          S_TAIL: begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            cmd_out  <= shadow;
            frame_ok <= 1'b1;
            if (ok_cnt != {CNT_W{1'b1}}) begin
              ok_cnt <= ok_cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed self-checking bench for cmd_frame_parser.
// Instance A: default widths, short timeout. Instance B: 2-bit counters for
// saturation. Both share din/din_vld; use_b steers the strobe.
module tb_cmd_frame_parser;

  localparam int TMO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, use_b, din_vld;
  logic [7:0] din;
  logic       din_vld_a, din_vld_b;

  assign din_vld_a = din_vld & ~use_b;
  assign din_vld_b = din_vld & use_b;

  logic [3:0] cmd_out_a, cmd_out_b;
  logic       frame_ok_a, frame_err_a, busy_a;
  logic       frame_ok_b, frame_err_b, busy_b;
  logic [2:0] err_code_a, err_code_b;
  logic [7:0] ok_cnt_a, err_cnt_a;
  logic [1:0] ok_cnt_b, err_cnt_b;

  int tests_run    = 0;
  int tests_failed = 0;

  cmd_frame_parser #(
    .NUM_CH(4), .MAX_CMDS(4), .HEAD(8'h55), .TAIL(8'hFF),
    .TIMEOUT_CYC(TMO), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst_a), .din_vld(din_vld_a), .din(din),
    .cmd_out(cmd_out_a), .frame_ok(frame_ok_a), .frame_err(frame_err_a),
    .err_code(err_code_a), .busy(busy_a), .ok_cnt(ok_cnt_a), .err_cnt(err_cnt_a)
  );

  cmd_frame_parser #(
    .NUM_CH(4), .MAX_CMDS(4), .HEAD(8'h55), .TAIL(8'hFF),
    .TIMEOUT_CYC(TMO), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst_b), .din_vld(din_vld_b), .din(din),
    .cmd_out(cmd_out_b), .frame_ok(frame_ok_b), .frame_err(frame_err_b),
    .err_code(err_code_b), .busy(busy_b), .ok_cnt(ok_cnt_b), .err_cnt(err_cnt_b)
  );

  // Called on a falling edge: present one byte for a single rising edge and
  // return on the next falling edge, where that edge's results are visible.
  task automatic applyStimulus(input logic [7:0] b);
    din     = b;
    din_vld = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
    din     = 8'h00;
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({cmd_out_a, frame_ok_a, frame_err_a, busy_a, err_code_a} !== 10'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {cmd_out_a, frame_ok_a, frame_err_a, busy_a, err_code_a}, 10'd0);
    end
    tests_run++;
    if ({ok_cnt_a, err_cnt_a} !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_counters: got %h expected %h", {ok_cnt_a, err_cnt_a}, 16'd0);
    end
  endtask

  task automatic test_set_and_toggle();
    applyStimulus(8'h55); applyStimulus(8'h02); applyStimulus(8'h41);
    applyStimulus(8'h43); applyStimulus(8'h00);
    tests_run++;
    if ({busy_a, frame_ok_a, cmd_out_a} !== 6'b10_0000) begin
      tests_failed++;
      $display("[TB] FAIL set_before_tail: got %b expected %b", {busy_a, frame_ok_a, cmd_out_a}, 6'b10_0000);
    end
    applyStimulus(8'hFF);
    tests_run++;
    if ({frame_ok_a, frame_err_a, busy_a} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL set_status: got %b expected %b", {frame_ok_a, frame_err_a, busy_a}, 3'b100);
    end
    tests_run++;
    if (cmd_out_a !== 4'b1010) begin
      tests_failed++;
      $display("[TB] FAIL set_cmd_out: got %b expected %b", cmd_out_a, 4'b1010);
    end
    tests_run++;
    if (ok_cnt_a !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL set_ok_cnt: got %0d expected %0d", ok_cnt_a, 1);
    end
    @(negedge clk);
    tests_run++;
    if (frame_ok_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL set_ok_one_cycle: got %b expected %b", frame_ok_a, 1'b0);
    end
    applyStimulus(8'hAA);
    tests_run++;
    if (busy_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL junk_ignored_busy: got %b expected %b", busy_a, 1'b0);
    end
    applyStimulus(8'h55); applyStimulus(8'h01); applyStimulus(8'h81);
    applyStimulus(8'h80); applyStimulus(8'hFF);
    tests_run++;
    if ({frame_ok_a, cmd_out_a, ok_cnt_a, err_cnt_a} !== {1'b1, 4'b1000, 8'd2, 8'd0}) begin
      tests_failed++;
      $display("[TB] FAIL toggle_frame: got %h expected %h",
               {frame_ok_a, cmd_out_a, ok_cnt_a, err_cnt_a}, {1'b1, 4'b1000, 8'd2, 8'd0});
    end
  endtask

  task automatic test_bad_checksum();
    applyStimulus(8'h55); applyStimulus(8'h01); applyStimulus(8'h02);
    applyStimulus(8'h04);
    tests_run++;
    if ({frame_ok_a, frame_err_a, busy_a, err_code_a} !== {3'b010, 3'd3}) begin
      tests_failed++;
      $display("[TB] FAIL chk_error: got %b expected %b",
               {frame_ok_a, frame_err_a, busy_a, err_code_a}, {3'b010, 3'd3});
    end
    applyStimulus(8'hFF);
    tests_run++;
    if ({frame_ok_a, frame_err_a, busy_a, cmd_out_a, err_cnt_a} !== {3'b000, 4'b1000, 8'd1}) begin
      tests_failed++;
      $display("[TB] FAIL chk_after_tail: got %h expected %h",
               {frame_ok_a, frame_err_a, busy_a, cmd_out_a, err_cnt_a}, {3'b000, 4'b1000, 8'd1});
    end
  endtask

  task automatic test_bad_cmd_len();
    applyStimulus(8'h55); applyStimulus(8'h01); applyStimulus(8'h45);
    tests_run++;
    if ({frame_err_a, busy_a, err_code_a} !== {2'b10, 3'd2}) begin
      tests_failed++;
      $display("[TB] FAIL bad_index: got %b expected %b", {frame_err_a, busy_a, err_code_a}, {2'b10, 3'd2});
    end
    applyStimulus(8'h55);
    tests_run++;
    if ({frame_err_a, busy_a, err_code_a} !== {2'b01, 3'd2}) begin
      tests_failed++;
      $display("[TB] FAIL err_code_hold: got %b expected %b", {frame_err_a, busy_a, err_code_a}, {2'b01, 3'd2});
    end
    applyStimulus(8'h00);
    tests_run++;
    if ({frame_err_a, busy_a, err_code_a} !== {2'b10, 3'd1}) begin
      tests_failed++;
      $display("[TB] FAIL len_zero: got %b expected %b", {frame_err_a, busy_a, err_code_a}, {2'b10, 3'd1});
    end
    applyStimulus(8'h55); applyStimulus(8'h04); applyStimulus(8'hC0);
    tests_run++;
    if ({frame_err_a, busy_a, err_code_a} !== {2'b10, 3'd2}) begin
      tests_failed++;
      $display("[TB] FAIL reserved_op: got %b expected %b", {frame_err_a, busy_a, err_code_a}, {2'b10, 3'd2});
    end
    applyStimulus(8'h55); applyStimulus(8'h05);
    tests_run++;
    if ({frame_err_a, busy_a, err_code_a, err_cnt_a, cmd_out_a} !== {2'b10, 3'd1, 8'd5, 4'b1000}) begin
      tests_failed++;
      $display("[TB] FAIL len_over_max: got %h expected %h",
               {frame_err_a, busy_a, err_code_a, err_cnt_a, cmd_out_a}, {2'b10, 3'd1, 8'd5, 4'b1000});
    end
  endtask

  task automatic test_timeout();
    applyStimulus(8'h55); applyStimulus(8'h01);
    repeat (TMO) @(negedge clk);
    tests_run++;
    if ({frame_err_a, busy_a} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL tmo_not_early: got %b expected %b", {frame_err_a, busy_a}, 2'b01);
    end
    @(negedge clk);
    tests_run++;
    if ({frame_err_a, busy_a, err_code_a, err_cnt_a} !== {2'b10, 3'd5, 8'd6}) begin
      tests_failed++;
      $display("[TB] FAIL tmo_fire: got %h expected %h",
               {frame_err_a, busy_a, err_code_a, err_cnt_a}, {2'b10, 3'd5, 8'd6});
    end
    @(negedge clk);
    applyStimulus(8'h55); applyStimulus(8'h01);
    repeat (TMO - 1) @(negedge clk);
    applyStimulus(8'h40);
    tests_run++;
    if ({frame_err_a, busy_a} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL tmo_keepalive: got %b expected %b", {frame_err_a, busy_a}, 2'b01);
    end
    applyStimulus(8'h41); applyStimulus(8'hFF);
    tests_run++;
    if ({frame_ok_a, frame_err_a, cmd_out_a, ok_cnt_a, err_cnt_a} !== {2'b10, 4'b1001, 8'd3, 8'd6}) begin
      tests_failed++;
      $display("[TB] FAIL tmo_then_commit: got %h expected %h",
               {frame_ok_a, frame_err_a, cmd_out_a, ok_cnt_a, err_cnt_a}, {2'b10, 4'b1001, 8'd3, 8'd6});
    end
  endtask

  task automatic test_reset_mid_frame();
    applyStimulus(8'h55); applyStimulus(8'h02); applyStimulus(8'h41);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    tests_run++;
    if ({cmd_out_a, busy_a, err_code_a, ok_cnt_a, err_cnt_a} !== 24'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_state: got %h expected %h",
               {cmd_out_a, busy_a, err_code_a, ok_cnt_a, err_cnt_a}, 24'd0);
    end
    applyStimulus(8'h43);
    tests_run++;
    if ({frame_ok_a, frame_err_a, busy_a} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_byte1: got %b expected %b", {frame_ok_a, frame_err_a, busy_a}, 3'b000);
    end
    applyStimulus(8'hFF);
    tests_run++;
    if ({frame_ok_a, frame_err_a, busy_a, cmd_out_a, ok_cnt_a} !== 15'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_byte2: got %h expected %h",
               {frame_ok_a, frame_err_a, busy_a, cmd_out_a, ok_cnt_a}, 15'd0);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] good [5];
    logic [7:0] bad  [5];
    good = '{8'h55, 8'h01, 8'h40, 8'h41, 8'hFF};
    bad  = '{8'h55, 8'h01, 8'h40, 8'h41, 8'h00};
    use_b = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 5; k++) applyStimulus(good[k]);
      if (f == 3) begin
        tests_run++;
        if (ok_cnt_b !== 2'd3) begin
          tests_failed++;
          $display("[TB] FAIL ok_sat_no_wrap: got %0d expected %0d", ok_cnt_b, 3);
        end
      end
    end
    tests_run++;
    if ({ok_cnt_b, cmd_out_b, err_cnt_b} !== {2'd3, 4'b0001, 2'd0}) begin
      tests_failed++;
      $display("[TB] FAIL ok_sat: got %b expected %b", {ok_cnt_b, cmd_out_b, err_cnt_b}, {2'd3, 4'b0001, 2'd0});
    end
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 5; k++) applyStimulus(bad[k]);
    end
    tests_run++;
    if ({err_cnt_b, err_code_b, ok_cnt_b, cmd_out_b} !== {2'd3, 3'd4, 2'd3, 4'b0001}) begin
      tests_failed++;
      $display("[TB] FAIL err_sat: got %b expected %b",
               {err_cnt_b, err_code_b, ok_cnt_b, cmd_out_b}, {2'd3, 3'd4, 2'd3, 4'b0001});
    end
    use_b = 1'b0;
  endtask

  initial begin
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    use_b   = 1'b0;
    din_vld = 1'b0;
    din     = 8'h00;
    @(negedge clk);
    test_reset();
    test_set_and_toggle();
    test_bad_checksum();
    test_bad_cmd_len();
    test_timeout();
    test_reset_mid_frame();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cmd_frame_parser.md
Name: cmd_frame_parser

Overview:
- Parametrised successor to the fixed LED/beep UART command decoder.
- Consumes the byte stream from uart_rx (din/din_vld) and parses variable-length frames: HEAD, LEN, LEN command bytes, CHK, TAIL.
- Applies per-channel on/off/toggle commands to a shadow vector, which is committed atomically to cmd_out only when the frame is fully valid.
- Adds checksum, inter-byte timeout, error reporting and frame statistics; cmd_out drives LED/beep/relay enables.

Parameters:
- NUM_CH, 4: number of output channels, 1..64.
- MAX_CMDS, 4: maximum command bytes per frame, 1..15.
- HEAD, 8'h55: frame start byte.
- TAIL, 8'hFF: frame end byte.
- TIMEOUT_CYC, 50000: idle clocks allowed between bytes inside a frame; 0 disables the timeout.
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- din_vld  in  1  one-cycle strobe, din valid.
- din  in  8  received byte.
- cmd_out  out  NUM_CH  committed channel states.
- frame_ok  out  1  one-cycle pulse on frame commit.
- frame_err  out  1  one-cycle pulse on frame abort.
- err_code  out  3  code of the last error; holds until the next error.
- busy  out  1  high whenever the FSM is not in S_IDLE.
- ok_cnt  out  CNT_W  saturating count of good frames.
- err_cnt  out  CNT_W  saturating count of aborted frames.

Behaviour:
- Reset: FSM to S_IDLE; cmd_out, shadow, checksum, counters and err_code all 0; frame_ok, frame_err and busy all 0. Reset mid-frame discards the partial frame.
- Clock and reset: a single clock, clk. Reset rst is synchronous and active-high.
- Byte handling: a byte is processed only when din_vld=1. Every state holds while din_vld=0.
- Command byte format: [7:6] op, where 00 = off, 01 = on, 10 = toggle, 11 = reserved. [5:0] = channel index.
- FSM transitions:
  - S_IDLE: on HEAD, load shadow with cmd_out, set chk to 0, go to S_LEN. Any other byte is ignored silently.
  - S_LEN: if LEN is 0 or greater than MAX_CMDS, error 1. Otherwise latch the remaining count, XOR LEN into chk, go to S_DATA.
  - S_DATA: if op is 11 or index is NUM_CH or above, error 2. Otherwise apply the op to the shadow bit, XOR the byte into chk, decrement the remaining count. When the count reaches 0, go to S_CHK.
  - Command ordering: commands apply in arrival order, so a later command to the same channel operates on the earlier result.
  - S_CHK: if the byte is not equal to chk, error 3. Otherwise go to S_TAIL.
  - S_TAIL: if the byte is TAIL, go to S_IDLE. On the next cycle cmd_out takes the shadow value, frame_ok pulses and ok_cnt increments. Any other byte gives error 4.
- Timeout: in any state other than S_IDLE, a counter clears on each din_vld and otherwise increments. When it reaches TIMEOUT_CYC, error 5. If din_vld coincides with the terminal count, the byte wins and no timeout fires.
- Error handling:
  - On any error: next cycle frame_err pulses, err_code is set, err_cnt increments, and the FSM returns to S_IDLE.
  - The shadow is discarded and cmd_out is unchanged.
  - The offending byte is consumed and is not re-evaluated as HEAD.
- Latency: 1 clk from the accepting din_vld to frame_ok/frame_err and to the cmd_out update.
- Counters: ok_cnt and err_cnt saturate at all-ones and never wrap.
- Status: frame_ok and frame_err are never asserted together. busy is registered from the FSM state.

Decomposition:
- cmd_frame_pkg holds:
  - state encoding for S_IDLE, S_LEN, S_DATA, S_CHK, S_TAIL;
  - op codes OP_OFF, OP_ON, OP_TOG, OP_RSV;
  - error codes ERR_LEN=1, ERR_CMD=2, ERR_CHK=3, ERR_TAIL=4, ERR_TMO=5.
- One natural sub-module: cmd_timeout_timer, with inputs clr, en and TIMEOUT_CYC, and output expire. It compiles out when TIMEOUT_CYC=0.
- The rest (FSM, shadow apply, checksum) lives in the top.

Test Plan:
- Set ch1 and ch3: from reset, send 55 02 41 43 00 FF → cmd_out=4'b1010, one frame_ok pulse, ok_cnt=1. Send AA 55 01 81 80 FF → the leading AA is ignored, ch1 toggles off, cmd_out=4'b1000, ok_cnt=2.
- Bad checksum: send 55 01 02 04 FF → frame_err with err_code=3 on the CHK byte. cmd_out stays 4'b1000. The trailing FF is ignored in S_IDLE; err_cnt=1.
- Bad index and bad length: send 55 01 45 → err_code=2 (index 5 ≥ NUM_CH). Then 55 00 → err_code=1. Then 55 05 → err_code=1 (5 > MAX_CMDS). err_cnt=4; busy low after each error.
- Timeout: send 55 01 with no further bytes for TIMEOUT_CYC clocks → err_code=5, busy=0. Then a byte at exactly terminal count −1 keeps the frame alive. A following valid frame 55 01 40 41 FF commits, ch0 goes on, and cmd_out=4'b1001.
- Reset mid-frame: send 55 02 41, then pulse rst for one cycle → cmd_out=0, busy=0, counters 0. A subsequent 43 FF produces no response.
- Saturation with CNT_W=2: 5 good frames → ok_cnt=3. 5 bad-tail frames (55 01 40 41 00) → err_cnt=3, err_code=4.
